// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences core reset/fetch enable, counts RUN cycles and retirements, ends runs on tohost, EBREAK or cycle limit.
// Optional tohost detection is compiled in with `define RUN_CTRL_TOHOST_EN.
module core_run_ctrl #(
    parameter int          RST_HOLD_CYCLES = 4,
    parameter int          CYCLE_LIMIT     = 1000,
    parameter int          CNT_WIDTH       = 32,
    parameter logic [31:0] HALT_INSTR      = 32'h0010_0073,
    parameter logic [31:0] TOHOST_ADDR     = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 wb_valid_i,
    input  logic [31:0]          wb_instr_i,
    input  logic                 st_valid_i,
    input  logic [31:0]          st_addr_i,
    input  logic [31:0]          st_data_i,
    output logic                 core_rst_o,
    output logic                 pc_incr_en_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o,
    output logic [CNT_WIDTH-1:0] retired_cnt_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [30:0]          exit_code_o
);
    localparam int HW = RST_HOLD_CYCLES > 1 ? $clog2(RST_HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [HW-1:0]        hold;
    logic [CNT_WIDTH-1:0] cycle_cnt, retired_cnt;
    logic                 pass, timeout;
    logic [30:0]          exit_code;
    logic                 tohost_hit, ebreak_hit, limit_hit, halt, enter_reset;
    logic [30:0]          tohost_code;

`ifdef RUN_CTRL_TOHOST_EN
    assign tohost_hit  = st_valid_i && st_addr_i == TOHOST_ADDR && st_data_i[0];
    assign tohost_code = st_data_i[31:1];
`else
    logic unused_st;
    assign unused_st   = ^{st_valid_i, st_addr_i, st_data_i};
    assign tohost_hit  = 1'b0;
    assign tohost_code = '0;
`endif

    assign ebreak_hit  = wb_valid_i && wb_instr_i == HALT_INSTR;
    assign limit_hit   = CYCLE_LIMIT != 0 && cycle_cnt == CNT_WIDTH'(CYCLE_LIMIT - 1);
    assign halt        = tohost_hit || ebreak_hit || limit_hit;
    assign enter_reset = state_nx == RESET && state != RESET;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        core_rst_o   = state == RUN || state == DONE;
        pc_incr_en_o = state == RUN;
        done_o       = state == DONE;
        case (state)
            IDLE:    state_nx = start_i ? RESET : IDLE;
            RESET:   state_nx = hold == '0 ? RUN : RESET;
            RUN:     state_nx = halt ? DONE : RUN;
            default: state_nx = start_i ? RESET : DONE;
        endcase
    end

    // Counters and result flags only move in RUN; a new run clears them on the way into RESET.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold        <= '0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
        end else if (enter_reset) begin
            hold        <= HW'(RST_HOLD_CYCLES - 1);
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
        end else if (state == RESET) begin
            hold <= hold - HW'(1);
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(cycle_cnt != '1);
            if (wb_valid_i) retired_cnt <= retired_cnt + CNT_WIDTH'(retired_cnt != '1);
            if (tohost_hit) begin
                pass      <= tohost_code == '0;
                exit_code <= tohost_code;
            end else if (ebreak_hit) begin
                pass <= 1'b1;
            end else if (limit_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    assign state_o       = state;
    assign cycle_cnt_o   = cycle_cnt;
    assign retired_cnt_o = retired_cnt;
    assign pass_o        = pass;
    assign timeout_o     = timeout;
`ifdef RUN_CTRL_TOHOST_EN
    assign exit_code_o   = exit_code;
`else
    logic unused_exit;
    assign unused_exit   = ^exit_code;
    assign exit_code_o   = '0;
`endif
endmodule
